signed_seq_multiplier: RTL and testbench
========================================

Name: signed_seq_multiplier

Overview:
Parametrised sequential multiplier with integrated sign handling. It is the next generation of the standalone combinational sign unit used in the MDR datapath. The block takes two WORD_LENGTH operands in two's-complement (signed mode) or unsigned form. It runs a radix-2 shift-add loop on operand magnitudes and applies the sign to produce a 2*WORD_LENGTH result with a ready pulse. It sits between the MDR operand registers and the result/display path.

Parameters:
WORD_LENGTH, 16, operand width in bits (>= 2); result is 2*WORD_LENGTH
CNT_WIDTH, $clog2(WORD_LENGTH+1), iteration counter width (derived, do not override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = operands are two's complement; 0 = unsigned
multiplicand  input  WORD_LENGTH  operand A, captured on accepted start
multiplier  input  WORD_LENGTH  operand B, captured on accepted start
result  output  2*WORD_LENGTH  product; two's complement if signed_mode, else unsigned
sign  output  1  sign of result (1 = negative)
busy  output  1  high while an operation is in progress
ready  output  1  one-cycle pulse: result/sign valid

Behaviour:
- Reset (async, active-high) sets state=IDLE, counter=0, all internal registers=0, result=0, sign=0, busy=0, ready=0. Reset asserted mid-operation aborts immediately; no ready pulse is produced.
- All outputs are registered.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - latch signed_mode
  - mag_a = |multiplicand|, mag_b = |multiplier| (two's-complement negation if signed_mode and MSB=1, else raw value)
  - sign_pend = signed_mode & (A[MSB] ^ B[MSB])
  - acc = 0, counter = 0, busy <= 1, state <= RUN
- RUN, each edge:
  - if mag_b[0], add mag_a shifted by counter into acc (2*WORD_LENGTH wide, no overflow possible)
  - shift mag_b right, counter++
  - when counter reaches WORD_LENGTH-1 at that edge, go to FIX; RUN lasts exactly WORD_LENGTH edges (E1..E_W)
- FIX, edge E_(W+1):
  - sign_final = sign_pend & (acc != 0); zero product is never negative, a new behaviour vs the combinational sign unit
  - result <= sign_final ? -acc : acc; sign <= sign_final
  - ready <= 1, busy <= 0, state <= IDLE
- Latency: ready is high in the cycle after edge E_(W+1), i.e. WORD_LENGTH+1 edges after the accepting edge. Ready drops at the next edge.
- result and sign hold until the next FIX or reset; they are not cleared by a new start.
- start while busy=1 is ignored; inputs do not affect an operation in flight after E0.
- start=1 in the cycle where ready=1 is accepted (state is already IDLE): back-to-back operations with no gap cycle.
- Most-negative operand: magnitude 2^(WORD_LENGTH-1) fits in WORD_LENGTH unsigned bits. (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) is positive and representable; no saturation or overflow flag.
- Unsigned mode: sign always 0; result is the full unsigned product.

Test Plan:
- WORD_LENGTH=8, signed_mode=0, A=255, B=255, start pulse -> busy high 9 cycles; ready pulse 9 edges after accept; result=16'hFE01, sign=0.
- signed_mode=1, A=8'hFD (-3), B=8'h05 -> result=16'hFFF1 (-15), sign=1; then A=8'h80, B=8'h80 -> result=16'h4000, sign=0.
- signed_mode=1, A=8'hF9 (-7), B=0 -> result=16'h0000, sign=0 (zero never flagged negative); A=0, B=8'h80 -> same.
- Start A=3, B=4; at edge E3 drive start=1 with A=9, B=9 -> ignored; result=12 with a single ready pulse. Start again in the ready cycle with A=2, B=5 -> accepted, result=10 after a further 9 edges.
- Start A=100, B=100; assert reset asynchronously at edge E4 (mid-clock) -> outputs 0 immediately, no ready pulse. After release, a new operation A=6, B=7 -> result=42.
- Sweep: 200 random signed/unsigned operand pairs at WORD_LENGTH=8 and 16 -> result and sign match a golden model; ready latency is always WORD_LENGTH+1.

Source files
------------

// File: rtl/signed_seq_multiplier.sv
// Radix-2 shift-add multiplier working on operand magnitudes.
// Applies the sign in a final FIX state; a zero product is never flagged negative.
module signed_seq_multiplier #(
    parameter int WORD_LENGTH = 16,
    parameter int CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    output logic [2*WORD_LENGTH-1:0]   result,
    output logic                       sign,
    output logic                       busy,
    output logic                       ready
);

    localparam int W2 = 2 * WORD_LENGTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_next;

    logic [CNT_WIDTH-1:0]   counter;
    logic [WORD_LENGTH-1:0] mag_b;
    logic [W2-1:0]          mag_a_sh;
    logic [W2-1:0]          acc;
    logic [W2-1:0]          acc_next;
    logic                   sign_pend;
    logic                   mode_q;
    logic                   last_iter;
    logic                   sign_final;

    function automatic logic [WORD_LENGTH-1:0] magnitude(
        input logic [WORD_LENGTH-1:0] v,
        input logic                   sm
    );
        return (sm && v[WORD_LENGTH-1]) ? -v : v;
    endfunction

    assign last_iter  = (counter == LAST);
    assign acc_next   = mag_b[0] ? acc + mag_a_sh : acc;
    assign sign_final = mode_q & sign_pend & (acc != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mag_a is kept pre-shifted so each RUN step adds it at the current weight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter   <= '0;
            mag_b     <= '0;
            mag_a_sh  <= '0;
            acc       <= '0;
            sign_pend <= 1'b0;
            mode_q    <= 1'b0;
            result    <= '0;
            sign      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= signed_mode;
                        mag_a_sh  <= W2'(magnitude(multiplicand, signed_mode));
                        mag_b     <= magnitude(multiplier, signed_mode);
                        sign_pend <= signed_mode &
                                     (multiplicand[WORD_LENGTH-1] ^
                                      multiplier[WORD_LENGTH-1]);
                        acc       <= '0;
                        counter   <= '0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    acc      <= acc_next;
                    mag_a_sh <= mag_a_sh << 1;
                    mag_b    <= mag_b >> 1;
                    counter  <= counter + CNT_WIDTH'(1);
                end
                FIX: begin
                    result <= sign_final ? -acc : acc;
                    sign   <= sign_final;
                    busy   <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
        end else begin
            ready <= (state == FIX);
        end
    end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Directed and random checks for signed_seq_multiplier at widths 8 and 16.
module tb_signed_seq_multiplier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] result8;
    logic        sign8, busy8, ready8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] result16;
    logic        sign16, busy16, ready16;

    int checks = 0;
    int errors = 0;
    int edges = 0;
    int bcnt = 0;

    always #5 clk = ~clk;

    signed_seq_multiplier #(.WORD_LENGTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8), .result(result8),
        .sign(sign8), .busy(busy8), .ready(ready8)
    );

    signed_seq_multiplier #(.WORD_LENGTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16), .result(result16),
        .sign(sign16), .busy(busy16), .ready(ready16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] golden(input int w, input bit sm,
                                           input logic [15:0] a, input logic [15:0] b);
        longint m  = (longint'(1) << w) - 1;
        longint sa = longint'(a) & m;
        longint sb = longint'(b) & m;
        longint p, pm;
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p  = sa * sb;
        pm = p & ((longint'(1) << (2 * w)) - 1);
        return {(sm && (p < 0)), pm[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic go8(input bit sm, input logic [7:0] a, input logic [7:0] b);
        sm8 = sm;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        edges = 0;
        bcnt = busy8 ? 1 : 0;
    endtask

    task automatic wait8(input string tag, input int lat);
        while (!ready8 && edges < 40) begin
            step();
            if (busy8) bcnt++;
        end
        chk({tag, " latency"}, edges, lat);
    endtask

    task automatic run_pair();
        int l8 = 0;
        int l16 = 0;
        int e = 0;
        logic [32:0] g8, g16;
        sm8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        sm16 = 1'($urandom_range(0, 1));
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        g8 = golden(8, sm8, {8'h0, a8}, {8'h0, b8});
        g16 = golden(16, sm16, a16, b16);
        start8 = 1'b1;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start16 = 1'b0;
        while ((l8 == 0 || l16 == 0) && e < 40) begin
            @(posedge clk);
            #1;
            e++;
            if (ready8 && l8 == 0) l8 = e;
            if (ready16 && l16 == 0) l16 = e;
        end
        chk("rand8 latency", l8, 9);
        chk("rand16 latency", l16, 17);
        chk("rand8 result", result8, g8[15:0]);
        chk("rand8 sign", sign8, g8[32]);
        chk("rand16 result", result16, g16[31:0]);
        chk("rand16 sign", sign16, g16[32]);
    endtask

    initial begin
        bit rdy_seen;

        repeat (2) @(posedge clk);
        #1;
        chk("reset result", result8, 16'h0);
        chk("reset sign", sign8, 1'b0);
        chk("reset busy", busy8, 1'b0);
        chk("reset ready", ready8, 1'b0);
        chk("reset result16", result16, 32'h0);
        reset = 1'b0;
        step();

        go8(1'b0, 8'd255, 8'd255);
        chk("busy after accept", busy8, 1'b1);
        wait8("u255", 9);
        chk("u255 busy cycles", bcnt, 9);
        chk("u255 result", result8, 16'hFE01);
        chk("u255 sign", sign8, 1'b0);
        step();
        chk("u255 ready drop", ready8, 1'b0);

        go8(1'b0, 8'd3, 8'd4);
        step();
        step();
        start8 = 1'b1;
        a8 = 8'd9;
        b8 = 8'd9;
        step();
        start8 = 1'b0;
        wait8("ign", 9);
        chk("ign result", result8, 16'd12);
        go8(1'b0, 8'd2, 8'd5);
        chk("b2b busy", busy8, 1'b1);
        chk("b2b result hold", result8, 16'd12);
        wait8("b2b", 9);
        chk("b2b result", result8, 16'd10);
        step();
        chk("b2b single pulse", ready8, 1'b0);
        chk("b2b idle", busy8, 1'b0);

        go8(1'b1, 8'hFD, 8'h05);
        wait8("m3x5", 9);
        chk("m3x5 result", result8, 16'hFFF1);
        chk("m3x5 sign", sign8, 1'b1);
        step();

        go8(1'b0, 8'd100, 8'd100);
        step();
        step();
        step();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst result", result8, 16'h0);
        chk("rst sign", sign8, 1'b0);
        chk("rst busy", busy8, 1'b0);
        chk("rst ready", ready8, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_seen = 1'b0;
        repeat (12) begin
            step();
            rdy_seen |= ready8;
        end
        chk("rst no ready", rdy_seen, 1'b0);
        go8(1'b0, 8'd6, 8'd7);
        wait8("6x7", 9);
        chk("6x7 result", result8, 16'd42);
        step();

        go8(1'b1, 8'h80, 8'h80);
        wait8("min sq", 9);
        chk("min sq result", result8, 16'h4000);
        chk("min sq sign", sign8, 1'b0);
        step();

        go8(1'b1, 8'hF9, 8'h00);
        wait8("m7x0", 9);
        chk("m7x0 result", result8, 16'h0000);
        chk("m7x0 sign", sign8, 1'b0);
        step();

        go8(1'b1, 8'h00, 8'h80);
        wait8("0xmin", 9);
        chk("0xmin result", result8, 16'h0000);
        chk("0xmin sign", sign8, 1'b0);
        step();

        for (int i = 0; i < 200; i++) begin
            run_pair();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
